div_nnbit_itera_arb: RTL and testbench

Round-robin scheduler that shares one iterative divider (e.g. `div_nnbit_s01_abs_itera`) among `NUM_REQ` requesters. Each requester submits an operand pair with a valid/ready handshake. The block issues at most one operation to the divider at a time, waits for its done pulse, and returns quotient and remainder tagged with the requester index through a valid/ready response port. It sits between the divide-issuing clients and the divider instance in the calc subsystem.

---
 rtl/div_nnbit_itera_arb.sv | 156 +++++++++++++++
 tb/tb_div_nnbit_itera_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_nnbit_itera_arb.sv
// Round-robin scheduler sharing one iterative divider among NUM_REQ valid/ready requesters.
// Optional macro DIV_ARB_DIVZERO_BYPASS_EN answers y==0 directly (res all ones, rem x) without the divider.
module div_nnbit_itera_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_signed,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_num_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_num_y,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_div_valid,
  output logic                          o_div_signed,
  output logic [DATA_WIDTH-1:0]         o_div_num_x,
  output logic [DATA_WIDTH-1:0]         o_div_num_y,
  input  logic [DATA_WIDTH-1:0]         i_div_res,
  input  logic [DATA_WIDTH-1:0]         i_div_rem,
  input  logic                          i_div_valid,
  output logic                          o_rsp_valid,
  output logic [ID_WIDTH-1:0]           o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_res,
  output logic [DATA_WIDTH-1:0]         o_rsp_rem,
  input  logic                          i_rsp_ready,
  output logic                          o_busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d, id_q, id_d, grant;
  logic                  sgn_q, sgn_d, sel_sgn, gnt_vld, bypass;
  logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d, rem_q, rem_d, sel_x, sel_y;
  logic [2*NUM_REQ-1:0]  vld_dbl;
  logic [NUM_REQ-1:0]    vld_rot;
  logic [ID_WIDTH:0]     idx_sum;

  // Rotate valids so bit 0 sits at the pointer; the lowest set bit is the grant offset.
  always_comb begin
    vld_dbl = {i_req_valid, i_req_valid} >> ptr_q;
    vld_rot = vld_dbl[NUM_REQ-1:0];
    gnt_vld = 1'b0;
    idx_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        gnt_vld = 1'b1;
        idx_sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
      end
    end
    if (idx_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
      idx_sum = idx_sum - (ID_WIDTH+1)'(NUM_REQ);
    end
    grant = idx_sum[ID_WIDTH-1:0];
  end

  always_comb begin
    sel_sgn = 1'b0;
    sel_x   = '0;
    sel_y   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == ID_WIDTH'(k)) begin
        sel_sgn = i_req_signed[k];
        sel_x   = i_req_num_x[k*DATA_WIDTH +: DATA_WIDTH];
        sel_y   = i_req_num_y[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`ifdef DIV_ARB_DIVZERO_BYPASS_EN
    bypass = (sel_y == '0);
`else
    bypass = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sgn_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sgn_q   <= sgn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sgn_d   = sgn_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d  = grant;
          sgn_d = sel_sgn;
          x_d   = sel_x;
          y_d   = sel_y;
          if (bypass) begin
            res_d   = '1;
            rem_d   = sel_x;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (i_div_valid) begin
          res_d   = i_div_res;
          rem_d   = i_div_rem;
          state_d = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          ptr_d   = (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + ID_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept strobe is masked during reset so every output reads zero while reset is held.
  always_comb begin
    o_req_ready = '0;
    if (state_q == IDLE && gnt_vld && i_rst_n) begin
      o_req_ready[grant] = 1'b1;
    end
    o_div_valid  = (state_q == ISSUE);
    o_rsp_valid  = (state_q == RESP);
    o_busy       = (state_q != IDLE);
    o_div_signed = sgn_q;
    o_div_num_x  = x_q;
    o_div_num_y  = y_q;
    o_rsp_id     = id_q;
    o_rsp_res    = res_q;
    o_rsp_rem    = rem_q;
  end
endmodule

// File: tb/tb_div_nnbit_itera_arb.sv
// Bench for div_nnbit_itera_arb: transaction-level model plus a 9-cycle divider model.
module tb_div_nnbit_itera_arb;
  localparam int N = 4, DW = 8, LAT = 9;
`ifdef DIV_ARB_DIVZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  i_req_valid = '0, i_req_signed = '0;
  logic [N*DW-1:0] i_req_num_x = '0, i_req_num_y = '0;
  logic [N-1:0]  o_req_ready;
  logic          o_div_valid, o_div_signed, o_rsp_valid, o_busy;
  logic [DW-1:0] o_div_num_x, o_div_num_y, o_rsp_res, o_rsp_rem;
  logic [1:0]    o_rsp_id;
  logic [DW-1:0] i_div_res = '0, i_div_rem = '0;
  logic          i_div_valid = 1'b0, i_rsp_ready = 1'b0;

  div_nnbit_itera_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_signed(i_req_signed),
    .i_req_num_x(i_req_num_x), .i_req_num_y(i_req_num_y),
    .o_req_ready(o_req_ready),
    .o_div_valid(o_div_valid), .o_div_signed(o_div_signed),
    .o_div_num_x(o_div_num_x), .o_div_num_y(o_div_num_y),
    .i_div_res(i_div_res), .i_div_rem(i_div_rem), .i_div_valid(i_div_valid),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_rsp_res(o_rsp_res), .o_rsp_rem(o_rsp_rem),
    .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  int nerr = 0, nchk = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference quotient/remainder (truncating); y==0 yields all ones and x.
  function automatic logic [2*DW-1:0] ref_div(input logic s, input logic [DW-1:0] x,
                                               input logic [DW-1:0] y);
    int a, b, q, r;
    if (y == '0) return {{DW{1'b1}}, x};
    if (s) begin
      a = int'($signed(x));
      b = int'($signed(y));
    end else begin
      a = int'(x);
      b = int'(y);
    end
    q = a / b;
    r = a % b;
    return {q[DW-1:0], r[DW-1:0]};
  endfunction

  // Divider model: done pulse LAT cycles after the issue cycle; ignores reset.
  int dcnt = 0;
  logic dm_s;
  logic [DW-1:0] dm_x, dm_y;
  always begin
    @(posedge clk);
    #1;
    i_div_valid = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        i_div_valid = 1'b1;
        {i_div_res, i_div_rem} = ref_div(dm_s, dm_x, dm_y);
      end
    end
    @(negedge clk);
    if (o_div_valid === 1'b1) begin
      dcnt = LAT;
      dm_s = o_div_signed;
      dm_x = o_div_num_x;
      dm_y = o_div_num_y;
    end
  end

  // Transaction model and per-cycle compare.
  bit m_inf = 1'b0, m_byp = 1'b0;
  int m_ptr = 0, m_acc = 0, m_id = 0, m_rise = -1;
  logic m_s;
  logic [DW-1:0] m_x, m_y, m_res, m_rem;
  int acc_cyc = -10, acc_port = -1, hs_count = 0;
  int last_id = -1, last_acc = 0, last_rise = 0, last_iss = -100, last_hs = 0;
  logic [DW-1:0] last_res, last_rem;
  int gq[$];

  always @(negedge clk) begin
    int g, k;
    bit rv;
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      if (rst_seen)
        chk("reset_outputs", 64'({o_req_ready, o_div_valid, o_div_signed, o_div_num_x, o_div_num_y,
                                  o_rsp_valid, o_rsp_id, o_rsp_res, o_rsp_rem, o_busy}), 64'(0));
      m_inf = 1'b0;
      m_ptr = 0;
    end else begin
      g = -1;
      if (!m_inf) begin
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (g < 0 && i_req_valid[k]) g = k;
        end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
      chk("busy", 64'(o_busy), 64'(m_inf));
      if (m_inf) begin
        chk("div_valid", 64'(o_div_valid), 64'(!m_byp && cyc == m_acc + 1));
        if (o_div_valid) last_iss = cyc;
        chk("div_operands", 64'({o_div_signed, o_div_num_x, o_div_num_y}), 64'({m_s, m_x, m_y}));
        if (!m_byp && m_rise < 0 && cyc >= m_acc + 2 && i_div_valid) m_rise = cyc + 1;
        rv = (m_rise >= 0 && cyc >= m_rise);
        chk("rsp_valid", 64'(o_rsp_valid), 64'(rv));
        if (rv) begin
          chk("rsp_id", 64'(o_rsp_id), 64'(m_id));
          chk("rsp_res", 64'(o_rsp_res), 64'(m_res));
          chk("rsp_rem", 64'(o_rsp_rem), 64'(m_rem));
          if (i_rsp_ready) begin
            hs_count++;
            last_id = int'(o_rsp_id); last_res = o_rsp_res; last_rem = o_rsp_rem;
            last_acc = m_acc; last_rise = m_rise; last_hs = cyc;
            m_ptr = (m_id + 1) % N;
            m_inf = 1'b0;
          end
        end
      end else begin
        chk("div_valid_idle", 64'(o_div_valid), 64'(0));
        chk("rsp_valid_idle", 64'(o_rsp_valid), 64'(0));
      end
      if (g >= 0) begin
        m_inf = 1'b1; m_acc = cyc; m_id = g;
        m_s = i_req_signed[g];
        m_x = i_req_num_x[g*DW +: DW];
        m_y = i_req_num_y[g*DW +: DW];
        {m_res, m_rem} = ref_div(m_s, m_x, m_y);
        m_byp  = BYP && (m_y == '0);
        m_rise = m_byp ? cyc + 1 : -1;
        acc_cyc = cyc; acc_port = g;
        gq.push_back(g);
      end
    end
  end

  // Requester side: a request stays pending until the model saw it accepted.
  bit pend[N], ps[N], rnd = 1'b0, keep_all = 1'b0;
  logic [DW-1:0] px[N], py[N];

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_req_valid[k] = pend[k];
      i_req_signed[k] = ps[k];
      i_req_num_x[k*DW +: DW] = px[k];
      i_req_num_y[k*DW +: DW] = py[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc_cyc == cyc - 1 && acc_port == k) pend[k] = 1'b0;
      if (!pend[k] && (keep_all || (rnd && $urandom_range(0, 3) == 0))) begin
        pend[k] = 1'b1;
        ps[k] = 1'($urandom_range(0, 1));
        px[k] = 8'($urandom);
        py[k] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
    end
    if (rnd) i_rsp_ready = ($urandom_range(0, 2) != 0);
    drive();
  endtask

  task automatic wait_hs(input int n, input int lim);
    int t = 0;
    while (hs_count < n && t < lim) begin step(); t++; end
    chk("handshake_in_time", 64'(hs_count >= n), 64'(1));
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    bit any;
    any = 1'b1;
    while (any && t < lim) begin
      step(); t++;
      any = m_inf;
      for (int k = 0; k < N; k++) any |= pend[k];
    end
    chk("drain_in_time", 64'(any), 64'(0));
  endtask

  initial begin
    int n, t, base, rise;
    for (int k = 0; k < N; k++) begin pend[k] = 0; ps[k] = 0; px[k] = '0; py[k] = '0; end
    repeat (3) step();
    rst_n = 1'b1;
    step(); step();

    // Signed port 0: 0x95 / 0x1D
    pend[0] = 1; ps[0] = 1; px[0] = 8'h95; py[0] = 8'h1D; i_rsp_ready = 1'b1;
    n = hs_count; wait_hs(n + 1, 60);
    chk("s_id", 64'(last_id), 64'(0));
    chk("s_res", 64'(last_res), 64'(8'hFD));
    chk("s_rem", 64'(last_rem), 64'(8'hEC));
    chk("s_issue_lat", 64'(last_iss - last_acc), 64'(1));
    chk("s_rsp_lat", 64'(last_rise - last_acc), 64'(11));

    // Unsigned port 2, same operands
    pend[2] = 1; ps[2] = 0; px[2] = 8'h95; py[2] = 8'h1D;
    n = hs_count; wait_hs(n + 1, 60);
    chk("u_id", 64'(last_id), 64'(2));
    chk("u_res", 64'(last_res), 64'(8'h05));
    chk("u_rem", 64'(last_rem), 64'(8'h04));

    // Reset while BUSY; the late done pulse must be ignored
    pend[3] = 1; ps[3] = 0; px[3] = 8'hC8; py[3] = 8'h03;
    t = 0;
    while (!(m_inf && cyc >= m_acc + 4) && t < 40) begin step(); t++; end
    chk("reached_busy", 64'(m_inf), 64'(1));
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n = hs_count;
    repeat (12) step();
    chk("no_rsp_after_reset", 64'(hs_count), 64'(n));

    // All four ports valid continuously
    base = gq.size();
    keep_all = 1'b1;
    n = hs_count; wait_hs(n + 5, 200);
    keep_all = 1'b0;
    for (int k = 0; k < N; k++) pend[k] = 0;
    drive();
    chk("rr_grant_count", 64'(gq.size() - base >= 5), 64'(1));
    if (gq.size() - base >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(gq[base + i]), 64'(i % N));
    wait_idle(60);

    // Response stall for 5 cycles with other requests waiting
    pend[1] = 1; ps[1] = 0; px[1] = 8'h64; py[1] = 8'h07; i_rsp_ready = 1'b0;
    t = 0;
    while (!(m_inf && m_rise >= 0 && cyc > m_rise) && t < 60) begin step(); t++; end
    chk("stall_rsp_seen", 64'(m_inf && m_rise >= 0), 64'(1));
    rise = m_rise;
    pend[0] = 1; ps[0] = 1; px[0] = 8'hF0; py[0] = 8'h05;
    pend[2] = 1; ps[2] = 0; px[2] = 8'h10; py[2] = 8'h03;
    drive();
    while (cyc < rise + 5 && t < 100) begin step(); t++; end
    i_rsp_ready = 1'b1;
    n = hs_count;
    step();
    chk("stall_hs_count", 64'(hs_count), 64'(n + 1));
    chk("stall_hs_cycle", 64'(last_hs - last_rise), 64'(5));
    chk("stall_res", 64'(last_res), 64'(8'h0E));
    chk("stall_rem", 64'(last_rem), 64'(8'h02));
    wait_idle(80);

    // Divide by zero: bypass or pass-through of the divider outputs
    pend[2] = 1; ps[2] = 0; px[2] = 8'h37; py[2] = 8'h00;
    n = hs_count; wait_hs(n + 1, 60);
    chk("z_res", 64'(last_res), 64'(8'hFF));
    chk("z_rem", 64'(last_rem), 64'(8'h37));
    chk("z_rsp_lat", 64'(last_rise - last_acc), 64'(BYP ? 1 : 11));
    chk("z_issued", 64'(last_iss > last_acc), 64'(!BYP));

    // Randomized traffic with random response backpressure
    rnd = 1'b1;
    repeat (400) step();
    rnd = 1'b0;
    i_rsp_ready = 1'b1;
    wait_idle(400);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
